sprite_rom_arbiter: RTL and testbench

Shares one single-port sprite/background pixel ROM among three requesters: P1 sprite fetch, P2 sprite fetch and background fetch. It sits between sprite_draw's fetch logic and the ROM in the pixel clock domain. It grants at most one read per cycle using round-robin and pipelines the ROM address. It tags each in-flight read so returning data is steered to the correct requester.

---
 rtl/sprite_rom_arbiter.sv | 129 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one single-port sprite/background ROM among P1, P2 and BG fetchers.
// Define SPRITE_ARB_STATS_EN to add per-frame grant counters (grant_cnt_p1/p2/bg).
module sprite_rom_arbiter #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 24,
  parameter int ROM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  frame_start,
  input  logic [2:0]            req,
  input  logic [ADDR_WIDTH-1:0] addr_p1,
  input  logic [ADDR_WIDTH-1:0] addr_p2,
  input  logic [ADDR_WIDTH-1:0] addr_bg,
  output logic [2:0]            gnt,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [2:0]            rdata_valid
`ifdef SPRITE_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt_p1,
  output logic [15:0]           grant_cnt_p2,
  output logic [15:0]           grant_cnt_bg
`endif
);

  logic [1:0]            last_grant;
  logic [1:0]            win_id;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [1:0]            rd_id_p0;
  logic                  tag_vld_p [ROM_LATENCY];
  logic [1:0]            tag_id_p  [ROM_LATENCY];

  // Search starts just after the last winner; first asserted request wins.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [2:0] g;
    g = 3'b000;
    unique case (last)
      2'd0:    g = r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
      2'd1:    g = r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
      default: g = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    endcase
    return g;
  endfunction

  always_comb begin
    gnt = 3'b000;
    if (reset && en) gnt = rr_pick(req, last_grant);
  end

  always_comb begin
    win_id   = 2'd0;
    win_addr = addr_p1;
    if (gnt[1]) begin
      win_id   = 2'd1;
      win_addr = addr_p2;
    end else if (gnt[2]) begin
      win_id   = 2'd2;
      win_addr = addr_bg;
    end
  end

  // Grant stage -> ROM address stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr   <= '0;
      rom_rd     <= 1'b0;
      rd_id_p0   <= 2'd0;
      last_grant <= 2'd2;
    end else begin
      rom_rd <= |gnt;
      if (|gnt) begin
        rom_addr   <= win_addr;
        rd_id_p0   <= win_id;
        last_grant <= win_id;
      end
    end
  end

  // ROM address stage -> tag pipeline, aligned with the ROM's read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < ROM_LATENCY; k++) begin
        tag_vld_p[k] <= 1'b0;
        tag_id_p[k]  <= 2'd0;
      end
    end else begin
      tag_vld_p[0] <= rom_rd;
      tag_id_p[0]  <= rd_id_p0;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        tag_vld_p[k] <= tag_vld_p[k-1];
        tag_id_p[k]  <= tag_id_p[k-1];
      end
    end
  end

  assign rdata       = rom_q;
  assign rdata_valid = tag_vld_p[ROM_LATENCY-1] ? (3'b001 << tag_id_p[ROM_LATENCY-1]) : 3'b000;

`ifdef SPRITE_ARB_STATS_EN
  // Frame clear takes priority but a coincident grant still counts.
  function automatic logic [15:0] cnt_next(input logic [15:0] c, input logic g, input logic clr);
    logic [15:0] n;
    n = c;
    if (clr)                      n = g ? 16'd1 : 16'd0;
    else if (g && c != 16'hFFFF)  n = c + 16'd1;
    return n;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_cnt_p1 <= 16'd0;
      grant_cnt_p2 <= 16'd0;
      grant_cnt_bg <= 16'd0;
    end else begin
      grant_cnt_p1 <= cnt_next(grant_cnt_p1, gnt[0], frame_start);
      grant_cnt_p2 <= cnt_next(grant_cnt_p2, gnt[1], frame_start);
      grant_cnt_bg <= cnt_next(grant_cnt_bg, gnt[2], frame_start);
    end
  end
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural ROM of latency LAT.
// Define SPRITE_ARB_STATS_EN to also exercise the grant counters.
module tb_sprite_rom_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 24;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          frame_start;
  logic [2:0]    req;
  logic [AW-1:0] addr_p1, addr_p2, addr_bg;
  logic [2:0]    gnt;
  logic [AW-1:0] rom_addr;
  logic          rom_rd;
  logic [DW-1:0] rom_q;
  logic [DW-1:0] rdata;
  logic [2:0]    rdata_valid;
`ifdef SPRITE_ARB_STATS_EN
  logic [15:0]   grant_cnt_p1, grant_cnt_p2, grant_cnt_bg;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .en(en), .frame_start(frame_start), .req(req),
    .addr_p1(addr_p1), .addr_p2(addr_p2), .addr_bg(addr_bg), .gnt(gnt),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_q(rom_q), .rdata(rdata),
    .rdata_valid(rdata_valid)
`ifdef SPRITE_ARB_STATS_EN
    , .grant_cnt_p1(grant_cnt_p1), .grant_cnt_p2(grant_cnt_p2), .grant_cnt_bg(grant_cnt_bg)
`endif
  );

  // ROM content: each word is a fixed tag above its own address
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {10'h155, a};
  endfunction

  logic [AW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_addr;
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_q = word(rom_pipe[LAT-1]);

  function automatic logic [AW-1:0] addr_of(input logic [2:0] oh);
    case (oh)
      3'b001:  return 14'h0010;
      3'b010:  return 14'h0020;
      default: return 14'h0030;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [2:0] seq [6];
  logic [2:0] exp_v;

  initial begin
    reset = 1'b0; en = 1'b1; frame_start = 1'b0; req = 3'b000;
    addr_p1 = '0; addr_p2 = '0; addr_bg = '0;
    seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    mid();
    chk("rst_rom_rd", 32'(rom_rd), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    cyc(); reset = 1'b1;

    // single P1 read: gnt at N, rom_rd at N+1, data at N+3
    cyc(); req = 3'b001; addr_p1 = 14'h0123;
    mid(); chk("t1_gnt", 32'(gnt), 32'h1);
    cyc(); req = 3'b000; addr_p1 = '0;
    mid(); chk("t1_rom_rd", 32'(rom_rd), 32'd1);
    chk("t1_rom_addr", 32'(rom_addr), 32'h0123);
    chk("t1_gnt_idle", 32'(gnt), 32'd0);
    cyc();
    mid(); chk("t1_rom_rd_low", 32'(rom_rd), 32'd0);
    chk("t1_rom_addr_hold", 32'(rom_addr), 32'h0123);
    chk("t1_rv_early", 32'(rdata_valid), 32'd0);
    cyc();
    mid(); chk("t1_rv", 32'(rdata_valid), 32'h1);
    chk("t1_rdata", 32'(rdata), 32'h554123);
    cyc();
    mid(); chk("t1_rv_after", 32'(rdata_valid), 32'd0);

    // fresh reset so P1 leads the rotation
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    addr_p1 = 14'h0010; addr_p2 = 14'h0020; addr_bg = 14'h0030;
    for (int i = 0; i < 9; i++) begin
      cyc(); req = (i < 6) ? 3'b111 : 3'b000;
      mid();
      if (i < 6) chk($sformatf("t2_gnt%0d", i), 32'(gnt), 32'(seq[i]));
      if (i >= 3) begin
        chk($sformatf("t2_rv%0d", i), 32'(rdata_valid), 32'(seq[i-3]));
        chk($sformatf("t2_rdata%0d", i), 32'(rdata), 32'(word(addr_of(seq[i-3]))));
      end
    end

    // after a P2 grant, BG is searched first
    cyc(); req = 3'b010;
    mid(); chk("t3_gnt_p2", 32'(gnt), 32'h2);
    cyc(); req = 3'b110;
    mid(); chk("t3_gnt_bg", 32'(gnt), 32'h4);
    cyc();
    mid(); chk("t3_gnt_p2b", 32'(gnt), 32'h2);
    cyc(); req = 3'b000;
    cyc(); cyc();

    // two reads in flight, then en low: they drain, no new grants
    cyc(); req = 3'b111; en = 1'b1;
    mid(); chk("t4_gnt_bg", 32'(gnt), 32'h4);
    cyc();
    mid(); chk("t4_gnt_p1", 32'(gnt), 32'h1);
    for (int j = 0; j < 5; j++) begin
      cyc(); en = 1'b0;
      mid();
      exp_v = (j == 1) ? 3'b100 : (j == 2) ? 3'b001 : 3'b000;
      chk($sformatf("t4_gnt_off%0d", j), 32'(gnt), 32'd0);
      chk($sformatf("t4_rv%0d", j), 32'(rdata_valid), 32'(exp_v));
      if (exp_v != 3'b000)
        chk($sformatf("t4_rdata%0d", j), 32'(rdata), 32'(word(addr_of(exp_v))));
    end
    cyc(); en = 1'b1;
    mid(); chk("t4_gnt_resume", 32'(gnt), 32'h2);

    // reset one cycle after a grant drops the in-flight read
    cyc(); reset = 1'b0; req = 3'b000;
    mid();
    chk("t5_rom_rd", 32'(rom_rd), 32'd0);
    chk("t5_rom_addr", 32'(rom_addr), 32'd0);
    chk("t5_rv", 32'(rdata_valid), 32'd0);
    chk("t5_gnt", 32'(gnt), 32'd0);
    cyc(); reset = 1'b1;
    for (int j = 0; j < 5; j++) begin
      mid(); chk($sformatf("t5_rv_post%0d", j), 32'(rdata_valid), 32'd0);
      cyc();
    end
    req = 3'b111;
    mid(); chk("t5_gnt_first", 32'(gnt), 32'h1);
    cyc(); req = 3'b000;

`ifdef SPRITE_ARB_STATS_EN
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    mid();
    chk("s_rst_p1", 32'(grant_cnt_p1), 32'd0);
    chk("s_rst_p2", 32'(grant_cnt_p2), 32'd0);
    chk("s_rst_bg", 32'(grant_cnt_bg), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(); req = 3'b001;
    end
    cyc(); req = 3'b000; frame_start = 1'b1;
    mid(); chk("s_p1_five", 32'(grant_cnt_p1), 32'd5);
    cyc(); frame_start = 1'b0;
    mid(); chk("s_p1_clear", 32'(grant_cnt_p1), 32'd0);
    cyc(); frame_start = 1'b1; req = 3'b001;
    cyc(); frame_start = 1'b0; req = 3'b000;
    mid(); chk("s_p1_coincide", 32'(grant_cnt_p1), 32'd1);
    chk("s_p2_zero", 32'(grant_cnt_p2), 32'd0);
    cyc(); req = 3'b001;
    repeat (70000) cyc();
    req = 3'b000;
    mid(); chk("s_p1_sat", 32'(grant_cnt_p1), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
